// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA pixel fetch block.
//   - 640x480 timing limits (visible area, counter totals, swap line)
//   - field widths for counters, coordinates, pixels and the read address
//   - swap controller state encoding (exported on a debug port)
//   - in_range(): half-open range test on a 10-bit counter
// ----------------------------------------------------------------------------
package vga_pkg;

    localparam int CNT_W   = 10;  // width of h_count / v_count
    localparam int COORD_W = 8;   // image x / y coordinate width
    localparam int PIX_W   = 8;   // grayscale pixel width
    localparam int ADDR_W  = 1 + 2 * COORD_W;  // {buf_sel, y, x}

    localparam logic [CNT_W-1:0] H_VISIBLE = 10'd640;
    localparam logic [CNT_W-1:0] V_VISIBLE = 10'd480;
    localparam logic [CNT_W-1:0] H_TOTAL   = 10'd800;
    localparam logic [CNT_W-1:0] V_TOTAL   = 10'd526;
    localparam logic [CNT_W-1:0] SWAP_LINE = 10'd480;

    // Swap controller states: idle, or a flip request waiting for the
    // swap point.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } swap_state_t;

    // lo <= c < hi, evaluated one bit wider so hi may equal 2**CNT_W.
    function automatic logic in_range(input logic [CNT_W-1:0] c,
                                      input logic [CNT_W:0]   lo,
                                      input logic [CNT_W:0]   hi);
        return ({1'b0, c} >= lo) && ({1'b0, c} < hi);
    endfunction

endpackage

// File: rtl/vga_pixel_fetch_if.sv
// ----------------------------------------------------------------------------
// vga_pixel_fetch_if
// Framebuffer read port between the pixel fetch pipeline and the memory.
//   mem_addr  : read address {buf_sel, y[7:0], x[7:0]}, driven by the master
//   mem_rdata : grayscale pixel, driven by the slave
// Protocol: fixed-latency read with no valid/ready handshake. The master
// presents a registered address; the slave must return the pixel for that
// address by the next clk edge and keep it stable while the address holds.
// modports: master = fetch pipeline, slave = framebuffer memory.
// ----------------------------------------------------------------------------
interface vga_pixel_fetch_if
    import vga_pkg::*;
();
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_rdata;

    modport master (output mem_addr, input  mem_rdata);
    modport slave  (input  mem_addr, output mem_rdata);
endinterface

// File: rtl/vga_swap_ctrl.sv
// ----------------------------------------------------------------------------
// vga_swap_ctrl
// Double-buffer flip controller. A rising swap request arms a pending flag;
// the flip happens only at the swap point (pixel_en with v==480, h==0), so
// the displayed buffer never changes inside a visible frame.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   pixel_en_i    : pixel-rate strobe, qualifies the swap point
//   h_count_i     : horizontal counter
//   v_count_i     : vertical counter
//   swap_req_i    : flip request (edge detected)
//   buf_sel_o     : currently displayed buffer
//   swap_ack_o    : one-clk pulse the cycle after a flip
//   state_o       : FSM state (debug)
// ----------------------------------------------------------------------------
module vga_swap_ctrl
    import vga_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             pixel_en_i,
    input  logic [CNT_W-1:0] h_count_i,
    input  logic [CNT_W-1:0] v_count_i,
    input  logic             swap_req_i,
    output logic             buf_sel_o,
    output logic             swap_ack_o,
    output swap_state_t      state_o
);

    swap_state_t state_q, state_d;
    logic        swap_req_q;
    logic        buf_sel_q;
    logic        swap_ack_q;
    logic        req_rise;
    logic        swap_point;
    logic        do_swap;

    assign req_rise   = swap_req_i & ~swap_req_q;
    assign swap_point = pixel_en_i && (v_count_i == SWAP_LINE) && (h_count_i == '0);

    // State register plus the flip/ack registers that it controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            swap_req_q <= 1'b0;
            buf_sel_q  <= 1'b0;
            swap_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            swap_req_q <= swap_req_i;
            buf_sel_q  <= buf_sel_q ^ do_swap;
            swap_ack_q <= do_swap;
        end
    end

    // Next state. A request landing on the swap point is consumed by that
    // swap directly and never enters PEND; repeat requests in PEND are
    // simply absorbed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_rise && !swap_point) state_d = S_PEND;
            S_PEND:  if (swap_point)              state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        do_swap = swap_point && ((state_q == S_PEND) || req_rise);
    end

    assign buf_sel_o  = buf_sel_q;
    assign swap_ack_o = swap_ack_q;
    assign state_o    = state_q;

endmodule

// File: rtl/vga_pixel_fetch.sv
// ----------------------------------------------------------------------------
// vga_pixel_fetch
// Two-stage pixel pipeline that places an IMG_W x IMG_H grayscale image at
// (OFF_X, OFF_Y) on a 640x480 display, fetching from a double-buffered
// framebuffer.
//   stage 1: window / visible decode, sync capture, read address issue
//   stage 2: colour select from mem_rdata, blank and sync outputs
// Both stages advance only when pixel_en=1, so every output is exactly two
// advances behind its counter inputs and holds between advances.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   pixel_en              : pixel-rate strobe
//   h_count, v_count      : display counters
//   vga_hs_i, vga_vs_i    : raw sync levels aligned with the counters
//   swap_req              : framebuffer flip request
//   mem                   : framebuffer read port (master)
//   vga_r/g/b             : colour outputs
//   vga_blank_n           : 1 = visible pixel
//   vga_hs_o, vga_vs_o    : sync aligned with the colour outputs
//   swap_ack              : one-clk flip pulse
//   buf_sel               : displayed buffer
//   swap_state            : swap controller state (debug)
// ----------------------------------------------------------------------------
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int OFF_X = 192,
    parameter int OFF_Y = 112
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pixel_en,
    input  logic [CNT_W-1:0]   h_count,
    input  logic [CNT_W-1:0]   v_count,
    input  logic               vga_hs_i,
    input  logic               vga_vs_i,
    input  logic               swap_req,
    vga_pixel_fetch_if.master  mem,
    output logic [PIX_W-1:0]   vga_r,
    output logic [PIX_W-1:0]   vga_g,
    output logic [PIX_W-1:0]   vga_b,
    output logic               vga_blank_n,
    output logic               vga_hs_o,
    output logic               vga_vs_o,
    output logic               swap_ack,
    output logic               buf_sel,
    output swap_state_t        swap_state
);

    localparam logic [CNT_W:0] X_LO = (CNT_W+1)'(OFF_X);
    localparam logic [CNT_W:0] X_HI = (CNT_W+1)'(OFF_X + IMG_W);
    localparam logic [CNT_W:0] Y_LO = (CNT_W+1)'(OFF_Y);
    localparam logic [CNT_W:0] Y_HI = (CNT_W+1)'(OFF_Y + IMG_H);

    // Stage-1 combinational decode
    logic               in_win_d;
    logic               visible_d;
    logic [COORD_W-1:0] x_d;
    logic [COORD_W-1:0] y_d;
    logic [ADDR_W-1:0]  addr_d;

    // Stage-1 registers
    logic               s1_valid_q;
    logic               s1_in_win_q;
    logic               s1_vis_q;
    logic               s1_hs_q;
    logic               s1_vs_q;
    logic [ADDR_W-1:0]  mem_addr_q;

    // Stage-2 registers
    logic [PIX_W-1:0]   pix_q;
    logic               blank_n_q;
    logic               hs_q;
    logic               vs_q;

    logic               buf_sel_w;

    vga_swap_ctrl u_swap_ctrl (
        .clk        (clk),
        .reset      (reset),
        .pixel_en_i (pixel_en),
        .h_count_i  (h_count),
        .v_count_i  (v_count),
        .swap_req_i (swap_req),
        .buf_sel_o  (buf_sel_w),
        .swap_ack_o (swap_ack),
        .state_o    (swap_state)
    );

    // Out-of-range counters (h>799, v>525) are forced out of the window even
    // if a parameter set would place the window there; visible needs no
    // guard because the visible limits sit below the totals.
    always_comb begin
        visible_d = (h_count < H_VISIBLE) && (v_count < V_VISIBLE);
        in_win_d  = (h_count < H_TOTAL) && (v_count < V_TOTAL) &&
                    in_range(h_count, X_LO, X_HI) &&
                    in_range(v_count, Y_LO, Y_HI);
        x_d       = COORD_W'(h_count - CNT_W'(OFF_X));
        y_d       = COORD_W'(v_count - CNT_W'(OFF_Y));
        addr_d    = {buf_sel_w, y_d, x_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_in_win_q <= 1'b0;
            s1_vis_q    <= 1'b0;
            s1_hs_q     <= 1'b1;
            s1_vs_q     <= 1'b1;
            mem_addr_q  <= '0;
            pix_q       <= '0;
            blank_n_q   <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
        end else if (pixel_en) begin
            // stage 1
            s1_valid_q  <= 1'b1;
            s1_in_win_q <= in_win_d;
            s1_vis_q    <= visible_d;
            s1_hs_q     <= vga_hs_i;
            s1_vs_q     <= vga_vs_i;
            // Address parks outside the window to avoid needless reads.
            if (in_win_d) begin
                mem_addr_q <= addr_d;
            end
            // stage 2: mem_rdata answers the address issued one advance ago
            pix_q       <= (s1_valid_q && s1_in_win_q) ? mem.mem_rdata : '0;
            blank_n_q   <= s1_valid_q && s1_vis_q;
            hs_q        <= s1_valid_q ? s1_hs_q : 1'b1;
            vs_q        <= s1_valid_q ? s1_vs_q : 1'b1;
        end
    end

    assign mem.mem_addr = mem_addr_q;
    assign vga_r        = pix_q;
    assign vga_g        = pix_q;
    assign vga_b        = pix_q;
    assign vga_blank_n  = blank_n_q;
    assign vga_hs_o     = hs_q;
    assign vga_vs_o     = vs_q;
    assign buf_sel      = buf_sel_w;

endmodule

// File: doc/vga_pixel_fetch.md
VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 Parameter: IMG_W, default 256, image width in pixels (power of two).
REQ-002 Parameter: IMG_H, default 256, image height in lines.
REQ-003 Parameter: OFF_X, default 192, first display column of the image window.
REQ-004 Parameter: OFF_Y, default 112, first display line of the image window.
REQ-005 Port: clk, input, 1 bit, single clock; every register in the block is clocked by clk.
REQ-006 Port: reset, input, 1 bit, synchronous, active-high.
REQ-007 Port: pixel_en, input, 1 bit, pixel-rate strobe; the pipeline advances only on cycles where it is 1.
REQ-008 Port: h_count, input, 10 bits, horizontal counter, 0..799, visible 0..639.
REQ-009 Port: v_count, input, 10 bits, vertical counter from the vsync generator, 0..525, visible 0..479.
REQ-010 Port: vga_hs_i / vga_vs_i, inputs, 1 bit each, raw sync levels aligned with the counters.
REQ-011 Port: swap_req, input, 1 bit, one-clk request to flip the displayed framebuffer.
REQ-012 Port: mem_addr, output, 17 bits, {buf_sel, y[7:0], x[7:0]} read address.
REQ-013 Port: mem_rdata, input, 8 bits, grayscale pixel, valid on the clk after mem_addr.
REQ-014 Port: vga_r / vga_g / vga_b, outputs, 8 bits each, pixel colour.
REQ-015 Port: vga_blank_n, output, 1 bit, 1 = visible pixel.
REQ-016 Port: vga_hs_o / vga_vs_o, outputs, 1 bit each, sync delayed to align with the colour outputs.
REQ-017 Port: swap_ack, output, 1 bit, one-clk pulse when the buffer flips.
REQ-018 Port: buf_sel, output, 1 bit, currently displayed buffer.

Function
REQ-019 Stage 1 (first pixel_en advance) shall register in_win = (OFF_X <= h < OFF_X+IMG_W) and (OFF_Y <= v < OFF_Y+IMG_H), visible = (h<640 and v<480), sync bits, and mem_addr.
REQ-020 Coordinates x and y shall be h-OFF_X and v-OFF_Y truncated to 8 bits; when in_win=0, mem_addr shall hold its previous value.
REQ-021 Stage 2 (next pixel_en advance) shall output r=g=b=mem_rdata if in_win, 0x00 if visible and not in_win, and 0x00 if not visible.
REQ-022 Total latency from counter input to colour, blank and sync outputs shall be exactly 2 pixel_en advances; all outputs shall hold between advances.
REQ-023 vga_blank_n shall be the stage-2 copy of visible; vga_hs_o and vga_vs_o shall be the stage-2 copies of vga_hs_i and vga_vs_i.
REQ-024 A rising swap_req shall set a pending flag; further requests while pending shall be absorbed, with no counting.
REQ-025 The swap point is the pixel_en cycle with v_count==480 and h_count==0; if pending there, buf_sel shall toggle, pending shall clear, and swap_ack shall pulse for exactly one clk.
REQ-026 A swap_req coincident with the swap point shall be consumed by that swap and shall leave pending=0.
REQ-027 buf_sel shall never change outside the swap point, so no visible frame is torn.
REQ-028 Counter values outside their ranges (h>799 or v>525) shall be treated as not visible and not in_win.

Reset
REQ-029 On reset: mem_addr=0, all colour outputs 0x00, vga_blank_n=0, vga_hs_o=1, vga_vs_o=1, buf_sel=0, pending=0, swap_ack=0, and pipeline valid bits cleared.
REQ-030 Reset shall win over pixel_en and swap_req in the same cycle; a pending swap shall be discarded.

Structure
REQ-031 A shared package vga_pkg shall hold H_VISIBLE=640, V_VISIBLE=480, H_TOTAL=800, V_TOTAL=526, SWAP_LINE=480, and the address-width constant.
REQ-032 One sub-module, vga_swap_ctrl, shall hold the pending/buf_sel/swap_ack logic; the pipeline shall live in the top level.

Verification
REQ-033 Reset, then pixel_en every clk and h=192, v=112 -> two advances later mem_addr=0x00000 was issued and vga_r equals mem_rdata.
REQ-034 h=100, v=100 -> output 0x00 with vga_blank_n=1; h=700, v=100 -> 0x00 with vga_blank_n=0.
REQ-035 h=447, v=367 -> mem_addr=0x0FFFF; h=448 -> out of window, black.
REQ-036 swap_req pulsed at v=200 -> buf_sel flips only at v=480, h=0, with a single swap_ack, and the next mem_addr carries bit16=1.
REQ-037 swap_req exactly at the swap point, then reset asserted mid-frame with pending=1 -> first request flips once; after reset, buf_sel=0 and no flip at the next swap point.
REQ-038 pixel_en every 2nd clk -> outputs change only on advances; latency is 2 advances; hs/vs are aligned with blank.
